// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control sequencer: opcodes, functs,
// ALU op codes, FSM state and instruction class.
package mips_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;

   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SLL   = 6'h00;

   localparam logic [3:0] ALU_NOP  = 4'b0000;
   localparam logic [3:0] ALU_ORI  = 4'b0001;
   localparam logic [3:0] ALU_SLL  = 4'b0010;
   localparam logic [3:0] ALU_ADD  = 4'b0011;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_DECODE    = 3'd1,
      ST_EXECUTE   = 3'd2,
      ST_MEM       = 3'd3,
      ST_WRITEBACK = 3'd4
   } state_e;

   typedef enum logic [2:0] {
      CLS_NONE = 3'd0,
      CLS_ADD  = 3'd1,
      CLS_SLL  = 3'd2,
      CLS_ADDI = 3'd3,
      CLS_ORI  = 3'd4,
      CLS_LW   = 3'd5,
      CLS_SW   = 3'd6,
      CLS_BEQ  = 3'd7
   } instr_class_e;

   // Classes whose second ALU operand is the immediate rather than rt.
   function automatic logic uses_imm(input instr_class_e cls);
      logic imm_s;
      case (cls)
         CLS_ADDI, CLS_ORI, CLS_LW, CLS_SW: imm_s = 1'b1;
         default:                           imm_s = 1'b0;
      endcase
      return imm_s;
   endfunction

   function automatic logic is_rtype(input instr_class_e cls);
      logic r_s;
      case (cls)
         CLS_ADD, CLS_SLL: r_s = 1'b1;
         default:          r_s = 1'b0;
      endcase
      return r_s;
   endfunction

endpackage

// File: rtl/multicycle_alu_ctrl_alu_op_decoder.sv
// Combinational opcode/funct classifier. beq is only recognised when
// MULTICYCLE_ALU_CTRL_BEQ_EN is defined; otherwise opcode 6'h04 is illegal.
module alu_op_decoder
   import mips_ctrl_pkg::*;
(
   input  logic [5:0]   opcode,
   input  logic [5:0]   funct,
   output instr_class_e instr_class,
   output logic [3:0]   alu_op,
   output logic         illegal
);

   instr_class_e cls_s;

   // Opcode/funct to instruction class.
   always_comb begin
      cls_s = CLS_NONE;
      case (opcode)
         OP_RTYPE: begin
            case (funct)
               FN_ADD:  cls_s = CLS_ADD;
               FN_SLL:  cls_s = CLS_SLL;
               default: cls_s = CLS_NONE;
            endcase
         end
         OP_ADDI: cls_s = CLS_ADDI;
         OP_ORI:  cls_s = CLS_ORI;
         OP_LW:   cls_s = CLS_LW;
         OP_SW:   cls_s = CLS_SW;
`ifdef MULTICYCLE_ALU_CTRL_BEQ_EN
         OP_BEQ:  cls_s = CLS_BEQ;
`endif
         default: cls_s = CLS_NONE;
      endcase
   end

   // Class to ALU operation code.
   always_comb begin
      alu_op = ALU_NOP;
      case (cls_s)
         CLS_ADD, CLS_ADDI, CLS_LW, CLS_SW, CLS_BEQ: alu_op = ALU_ADD;
         CLS_ORI:                                   alu_op = ALU_ORI;
         CLS_SLL:                                   alu_op = ALU_SLL;
         default:                                   alu_op = ALU_NOP;
      endcase
   end

   assign instr_class = cls_s;
   assign illegal     = (cls_s == CLS_NONE);

endmodule

// File: rtl/multicycle_alu_ctrl.sv
// Multicycle control sequencer driving the datapath ALU and memory strobes.
// Optional beq support: MULTICYCLE_ALU_CTRL_BEQ_EN.
module multicycle_alu_ctrl
   import mips_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        instr_valid_i,
   output logic        instr_ready_o,
   input  logic [31:0] instruction_i,
   input  logic        zero_i,
   output logic [3:0]  alu_operation_o,
   output logic [4:0]  shamt_o,
   output logic        alu_src_b_o,
   output logic        zero_ext_o,
   output logic        reg_dst_o,
   output logic        reg_write_o,
   output logic        mem_read_o,
   output logic        mem_write_o,
   output logic        mem_to_reg_o,
   output logic        branch_taken_o,
   output logic        done_o,
   output logic        illegal_o
);

   state_e       state_r;
   state_e       next_state_s;
   logic [31:0]  instr_r;
   instr_class_e cls_s;
   logic [3:0]   alu_op_s;
   logic         illegal_s;
   logic         accept_s;
   logic         alu_active_s;

   alu_op_decoder u_dec (
      .opcode      (instr_r[31:26]),
      .funct       (instr_r[5:0]),
      .instr_class (cls_s),
      .alu_op      (alu_op_s),
      .illegal     (illegal_s)
   );

   assign accept_s = instr_valid_i && (state_r == ST_IDLE);

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Instruction latch; only written on acceptance so later input changes are ignored.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         instr_r <= 32'h0000_0000;
      end else if (accept_s) begin
         instr_r <= instruction_i;
      end else begin
         instr_r <= instr_r;
      end
   end

   // Next-state logic.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               next_state_s = ST_DECODE;
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_DECODE: begin
            if (illegal_s) begin
               next_state_s = ST_IDLE;
            end else begin
               next_state_s = ST_EXECUTE;
            end
         end
         ST_EXECUTE: begin
            case (cls_s)
               CLS_LW, CLS_SW: next_state_s = ST_MEM;
               CLS_BEQ:        next_state_s = ST_IDLE;
               default:        next_state_s = ST_WRITEBACK;
            endcase
         end
         ST_MEM: begin
            if (cls_s == CLS_LW) begin
               next_state_s = ST_WRITEBACK;
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_WRITEBACK: next_state_s = ST_IDLE;
         default:      next_state_s = ST_IDLE;
      endcase
   end

   assign alu_active_s = (state_r == ST_EXECUTE) || (state_r == ST_MEM) ||
                         (state_r == ST_WRITEBACK);

   // Moore outputs from state and latched instruction (branch also looks at zero_i).
   always_comb begin
      instr_ready_o   = 1'b0;
      alu_operation_o = ALU_NOP;
      shamt_o         = 5'd0;
      alu_src_b_o     = 1'b0;
      zero_ext_o      = 1'b0;
      reg_dst_o       = 1'b0;
      reg_write_o     = 1'b0;
      mem_read_o      = 1'b0;
      mem_write_o     = 1'b0;
      mem_to_reg_o    = 1'b0;
      branch_taken_o  = 1'b0;
      done_o          = 1'b0;
      illegal_o       = 1'b0;

      if (alu_active_s) begin
         alu_operation_o = alu_op_s;
         alu_src_b_o     = uses_imm(cls_s);
         zero_ext_o      = (cls_s == CLS_ORI);
         if (cls_s == CLS_SLL) begin
            shamt_o = instr_r[10:6];
         end else begin
            shamt_o = 5'd0;
         end
      end else begin
         alu_operation_o = ALU_NOP;
      end

      case (state_r)
         ST_IDLE:   instr_ready_o = 1'b1;
         ST_DECODE: illegal_o     = illegal_s;
         ST_EXECUTE: begin
            if (cls_s == CLS_BEQ) begin
`ifdef MULTICYCLE_ALU_CTRL_BEQ_EN
               branch_taken_o = zero_i;
`else
               branch_taken_o = 1'b0;
`endif
               done_o = 1'b1;
            end else begin
               done_o = 1'b0;
            end
         end
         ST_MEM: begin
            mem_read_o  = (cls_s == CLS_LW);
            mem_write_o = (cls_s == CLS_SW);
            done_o      = (cls_s == CLS_SW);
         end
         ST_WRITEBACK: begin
            reg_write_o  = 1'b1;
            reg_dst_o    = is_rtype(cls_s);
            mem_to_reg_o = (cls_s == CLS_LW);
            done_o       = 1'b1;
         end
         default: instr_ready_o = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_multicycle_alu_ctrl.sv
// Self-checking bench: directed and random instructions against a cycle-count
// reference model derived from per-instruction latency and strobe timing.
module tb_multicycle_alu_ctrl;

`ifdef MULTICYCLE_ALU_CTRL_BEQ_EN
   localparam bit BEQ_EN = 1'b1;
`else
   localparam bit BEQ_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        instr_valid_i = 1'b0;
   logic        instr_ready_o;
   logic [31:0] instruction_i = 32'h0;
   logic        zero_i = 1'b0;
   logic [3:0]  alu_operation_o;
   logic [4:0]  shamt_o;
   logic        alu_src_b_o, zero_ext_o, reg_dst_o, reg_write_o;
   logic        mem_read_o, mem_write_o, mem_to_reg_o;
   logic        branch_taken_o, done_o, illegal_o;

   int n_tests = 0;
   int n_fail  = 0;

   multicycle_alu_ctrl dut (
      .clk             (clk),
      .reset           (reset),
      .instr_valid_i   (instr_valid_i),
      .instr_ready_o   (instr_ready_o),
      .instruction_i   (instruction_i),
      .zero_i          (zero_i),
      .alu_operation_o (alu_operation_o),
      .shamt_o         (shamt_o),
      .alu_src_b_o     (alu_src_b_o),
      .zero_ext_o      (zero_ext_o),
      .reg_dst_o       (reg_dst_o),
      .reg_write_o     (reg_write_o),
      .mem_read_o      (mem_read_o),
      .mem_write_o     (mem_write_o),
      .mem_to_reg_o    (mem_to_reg_o),
      .branch_taken_o  (branch_taken_o),
      .done_o          (done_o),
      .illegal_o       (illegal_o)
   );

   always #5 clk = ~clk;

   // Vector order: ready, aluop[4], shamt[5], srcb, zext, rdst, rw, mr, mw, m2r, br, done, ill
   function automatic logic [19:0] obs_vec();
      return {instr_ready_o, alu_operation_o, shamt_o, alu_src_b_o, zero_ext_o,
              reg_dst_o, reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o,
              branch_taken_o, done_o, illegal_o};
   endfunction

   // Cycles from acceptance to done (illegal: to the illegal pulse).
   function automatic int exp_lat(input logic [31:0] ins);
      logic [5:0] op;
      logic [5:0] fn;
      op = ins[31:26];
      fn = ins[5:0];
      if (op == 6'h00 && (fn == 6'h20 || fn == 6'h00)) return 3;
      if (op == 6'h08 || op == 6'h0D || op == 6'h2B) return 3;
      if (op == 6'h23) return 4;
      if (op == 6'h04 && BEQ_EN) return 2;
      return 1;
   endfunction

   function automatic logic [19:0] exp_vec(input logic [31:0] ins, input int k, input logic z);
      logic [5:0] op, fn;
      logic add_i, sll_i, addi_i, ori_i, lw_i, sw_i, beq_i, legal;
      logic       rdy, srcb, zext, rdst, rw, mr, mw, m2r, br, dn, ill;
      logic [3:0] aop;
      logic [4:0] sh;
      int         lat;
      op = ins[31:26];
      fn = ins[5:0];
      add_i  = (op == 6'h00) && (fn == 6'h20);
      sll_i  = (op == 6'h00) && (fn == 6'h00);
      addi_i = (op == 6'h08);
      ori_i  = (op == 6'h0D);
      lw_i   = (op == 6'h23);
      sw_i   = (op == 6'h2B);
      beq_i  = (op == 6'h04) && BEQ_EN;
      legal  = add_i | sll_i | addi_i | ori_i | lw_i | sw_i | beq_i;
      lat    = exp_lat(ins);
      {rdy, srcb, zext, rdst, rw, mr, mw, m2r, br, dn, ill} = 11'b0;
      aop = 4'b0000;
      sh  = 5'd0;
      if (k == 0 || k > lat) begin
         rdy = 1'b1;
      end else if (!legal) begin
         ill = (k == 1);
      end else if (k >= 2) begin
         aop  = ori_i ? 4'b0001 : (sll_i ? 4'b0010 : 4'b0011);
         sh   = sll_i ? ins[10:6] : 5'd0;
         srcb = addi_i | ori_i | lw_i | sw_i;
         zext = ori_i;
         if (beq_i) begin
            br = z;
            dn = 1'b1;
         end else if (lw_i) begin
            mr = (k == 3);
            if (k == 4) begin
               rw = 1'b1; m2r = 1'b1; dn = 1'b1;
            end
         end else if (sw_i) begin
            if (k == 3) begin
               mw = 1'b1; dn = 1'b1;
            end
         end else if (k == 3) begin
            rw = 1'b1; rdst = add_i | sll_i; dn = 1'b1;
         end
      end
      return {rdy, aop, sh, srcb, zext, rdst, rw, mr, mw, m2r, br, dn, ill};
   endfunction

   task automatic check(input string tag, input logic [19:0] obs, input logic [19:0] exp_v);
      n_tests++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s observed=%05h expected=%05h", tag, obs, exp_v);
      end
   endtask

   // Called at a negedge in IDLE; returns at the negedge of the first IDLE cycle after.
   task automatic run_instr(input logic [31:0] ins, input logic z, input string tag);
      int lat;
      lat = exp_lat(ins);
      zero_i        = z;
      instruction_i = ins;
      instr_valid_i = 1'b1;
      check({tag, "/c0"}, obs_vec(), exp_vec(ins, 0, z));
      @(posedge clk);
      for (int k = 1; k <= lat + 1; k++) begin
         #1;
         instruction_i = $urandom;
         instr_valid_i = (k <= lat) ? 1'($urandom_range(0, 1)) : 1'b0;
         @(negedge clk);
         check($sformatf("%s/c%0d", tag, k), obs_vec(), exp_vec(ins, k, z));
         if (k <= lat) @(posedge clk);
      end
   endtask

   function automatic logic [31:0] rand_instr(input int sel);
      logic [31:0] r;
      r = $urandom;
      case (sel)
         0: return {6'h00, r[25:11], 5'd0, 6'h20};
         1: return {6'h00, r[25:6], 6'h00};
         2: return {6'h08, r[25:0]};
         3: return {6'h0D, r[25:0]};
         4: return {6'h23, r[25:0]};
         5: return {6'h2B, r[25:0]};
         6: return {6'h04, r[25:0]};
         7: return r;
         default: return {6'h00, r[25:0]};
      endcase
   endfunction

   initial begin
      logic [31:0] add_w;
      add_w = 32'h0022_1820;

      #2 reset = 1'b1;
      #1 check("reset", obs_vec(), exp_vec(32'h0, 0, 1'b0));
      @(negedge clk);
      reset = 1'b0;

      run_instr(add_w,         1'b0, "add");
      run_instr(32'h0001_1100, 1'b0, "sll");
      run_instr(32'h3401_FFFF, 1'b0, "ori");
      run_instr(32'h8C22_0004, 1'b0, "lw");
      run_instr(32'hAC22_0004, 1'b1, "sw_b2b");
      run_instr(32'h1022_0003, 1'b1, "beq_z1");
      run_instr(32'h1022_0003, 1'b0, "beq_z0");
      run_instr(32'hFC00_0000, 1'b0, "op3f");
      run_instr(32'h0022_1821, 1'b0, "bad_funct");

      // Reset in the middle of EXECUTE abandons the instruction.
      instruction_i = add_w;
      instr_valid_i = 1'b1;
      @(posedge clk);
      #1 instr_valid_i = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rst_pre_exec", obs_vec(), exp_vec(add_w, 2, 1'b0));
      #2 reset = 1'b1;
      #1 check("rst_async", obs_vec(), exp_vec(32'h0, 0, 1'b0));
      @(negedge clk);
      check("rst_held", obs_vec(), exp_vec(32'h0, 0, 1'b0));
      reset = 1'b0;
      run_instr(32'h3401_FFFF, 1'b0, "ori_after_rst");

      for (int i = 0; i < 40; i++) begin
         run_instr(rand_instr($urandom_range(0, 8)), 1'($urandom_range(0, 1)),
                   $sformatf("rnd%0d", i));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
